// File: rtl/data_cache_if.sv
// CPU-side and memory-side signal bundle for the direct-mapped data cache.
// The cache takes the slave view; the CPU/memory environment takes the master view.
interface data_cache_if;
  logic        READ;
  logic        WRITE;
  logic [7:0]  ADDRESS;
  logic [7:0]  WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  modport slave (
    input  READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
    output READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );

  modport master (
    output READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
    input  READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped write-back byte cache: 8 lines x 4 bytes, 3-bit tag.
// Hits are served combinationally; misses stall through WRITEBACK/FETCH.
//
// state     | meaning
// IDLE      | serve hits with no stall; detect misses
// WRITEBACK | push dirty victim line to main memory
// FETCH     | refill the line from main memory
module data_cache (
  input logic         CLK,
  input logic         RESET,
  data_cache_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH} state_e;

  state_e           state_q, state_d;
  logic [7:0]       valid_q, valid_d;
  logic [7:0]       dirty_q, dirty_d;
  logic [7:0][2:0]  tag_q, tag_d;
  logic [7:0][31:0] data_q, data_d;

  logic [2:0]  idx;
  logic [2:0]  tag_in;
  logic [1:0]  off;
  logic        rd_req;
  logic        wr_req;
  logic        hit;

  logic [7:0]  rdata;
  logic        busy;
  logic        mem_rd;
  logic        mem_wr;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;

  assign idx    = bus.ADDRESS[4:2];
  assign tag_in = bus.ADDRESS[7:5];
  assign off    = bus.ADDRESS[1:0];
  // READ and WRITE together is treated as a plain read
  assign rd_req = bus.READ;
  assign wr_req = bus.WRITE & ~bus.READ;
  assign hit    = valid_q[idx] & (tag_q[idx] == tag_in);

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    dirty_d   = dirty_q;
    tag_d     = tag_q;
    data_d    = data_q;
    rdata     = 8'h00;
    busy      = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = 6'h00;
    mem_wdata = 32'h0;

    case (state_q)
      IDLE: begin
        if (rd_req || wr_req) begin
          if (hit) begin
            if (rd_req) begin
              rdata = data_q[idx][{off, 3'b000} +: 8];
            end else begin
              data_d[idx][{off, 3'b000} +: 8] = bus.WRITEDATA;
              dirty_d[idx] = 1'b1;
            end
          end else begin
            busy    = 1'b1;
            state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : FETCH;
          end
        end
      end
      WRITEBACK: begin
        busy      = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = {tag_q[idx], idx};
        mem_wdata = data_q[idx];
        if (!bus.MEM_BUSYWAIT) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        busy     = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = bus.ADDRESS[7:2];
        if (!bus.MEM_BUSYWAIT) begin
          data_d[idx]  = bus.MEM_READDATA;
          tag_d[idx]   = tag_in;
          valid_d[idx] = 1'b1;
          dirty_d[idx] = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // IDLE misses would otherwise raise BUSYWAIT while reset holds valid bits clear
    if (!RESET) begin
      busy  = 1'b0;
      rdata = 8'h00;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      valid_q <= 8'h00;
      dirty_q <= 8'h00;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  always_ff @(posedge CLK) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign bus.READDATA      = rdata;
  assign bus.BUSYWAIT      = busy;
  assign bus.MEM_READ      = mem_rd;
  assign bus.MEM_WRITE     = mem_wr;
  assign bus.MEM_ADDRESS   = mem_addr;
  assign bus.MEM_WRITEDATA = mem_wdata;

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: a line/memory model predicts every cycle of each
// access (stall length, memory traffic, read byte); literal values pin the model.
module tb_data_cache;

  logic CLK;
  logic RESET;
  data_cache_if bus ();

  data_cache dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct packed {
    logic        busy;
    logic        mrd;
    logic        mwr;
    logic [5:0]  maddr;
    logic [31:0] mwd;
    logic        rdv;
    logic [7:0]  rd;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic [31:0] m_data [8];
  logic [2:0]  m_tag  [8];
  bit          m_v    [8];
  bit          m_d    [8];
  logic [31:0] mem    [64];

  logic        obs_wb_seen;
  logic [5:0]  obs_wb_addr;
  logic [31:0] obs_wb_data;
  logic [5:0]  obs_fa;
  logic [7:0]  obs_rd;
  int          obs_busy_cycles;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic exp_t mk(input logic busy, input logic mrd, input logic mwr,
                              input logic [5:0] maddr, input logic [31:0] mwd,
                              input logic rdv, input logic [7:0] rd);
    exp_t e;
    e.busy = busy; e.mrd = mrd; e.mwr = mwr; e.maddr = maddr;
    e.mwd = mwd; e.rdv = rdv; e.rd = rd;
    return e;
  endfunction

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("busywait",      {31'b0, bus.BUSYWAIT},  {31'b0, e.busy});
      chk("mem_read",      {31'b0, bus.MEM_READ},  {31'b0, e.mrd});
      chk("mem_write",     {31'b0, bus.MEM_WRITE}, {31'b0, e.mwr});
      chk("mem_address",   {26'b0, bus.MEM_ADDRESS}, {26'b0, e.maddr});
      chk("mem_writedata", bus.MEM_WRITEDATA, e.mwd);
      if (e.rdv) chk("readdata", {24'b0, bus.READDATA}, {24'b0, e.rd});
    end
  end

  task automatic cycle(input exp_t e, input logic mbw, input logic [31:0] mrdata);
    bus.MEM_BUSYWAIT = mbw;
    bus.MEM_READDATA = mrdata;
    exp_q.push_back(e);
    @(negedge CLK);
    #1;
    if (bus.MEM_WRITE) begin
      obs_wb_seen = 1'b1;
      obs_wb_addr = bus.MEM_ADDRESS;
      obs_wb_data = bus.MEM_WRITEDATA;
    end
    if (bus.MEM_READ) obs_fa = bus.MEM_ADDRESS;
    if (bus.BUSYWAIT) obs_busy_cycles++;
    obs_rd = bus.READDATA;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_cycle();
    bus.READ  = 1'b0;
    bus.WRITE = 1'b0;
    cycle(mk(1'b0, 1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 8'h00), 1'b1, 32'h0);
  endtask

  // One CPU access; wl/fl are memory cycles spent in writeback/fetch when they happen
  task automatic run_access(input logic rd, input logic wr, input logic [7:0] addr,
                            input logic [7:0] wd, input int wl, input int fl);
    logic [2:0] idx;
    logic [2:0] tg;
    logic [1:0] off;
    idx = addr[4:2];
    tg  = addr[7:5];
    off = addr[1:0];
    obs_wb_seen     = 1'b0;
    obs_wb_addr     = 6'h00;
    obs_wb_data     = 32'h0;
    obs_fa          = 6'h3f;
    obs_busy_cycles = 0;
    bus.READ      = rd;
    bus.WRITE     = wr;
    bus.ADDRESS   = addr;
    bus.WRITEDATA = wd;
    if (!(m_v[idx] && m_tag[idx] == tg)) begin
      cycle(mk(1'b1, 1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 8'h00), 1'b1, 32'h0);
      if (m_v[idx] && m_d[idx]) begin
        for (int k = 0; k < wl; k++)
          cycle(mk(1'b1, 1'b0, 1'b1, {m_tag[idx], idx}, m_data[idx], 1'b0, 8'h00),
                (k != wl - 1), 32'h0);
        mem[{m_tag[idx], idx}] = m_data[idx];
      end
      for (int k = 0; k < fl; k++)
        cycle(mk(1'b1, 1'b1, 1'b0, addr[7:2], 32'h0, 1'b0, 8'h00),
              (k != fl - 1), mem[addr[7:2]]);
      m_data[idx] = mem[addr[7:2]];
      m_tag[idx]  = tg;
      m_v[idx]    = 1'b1;
      m_d[idx]    = 1'b0;
    end
    cycle(mk(1'b0, 1'b0, 1'b0, 6'h00, 32'h0, rd, m_data[idx][off*8 +: 8]), 1'b1, 32'h0);
    if (wr && !rd) begin
      m_data[idx][off*8 +: 8] = wd;
      m_d[idx] = 1'b1;
    end
    bus.READ  = 1'b0;
    bus.WRITE = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA0B0C0D0 ^ (i * 32'h01010101);
    mem[0] = 32'h44332211;
    for (int i = 0; i < 8; i++) begin
      m_v[i] = 1'b0; m_d[i] = 1'b0; m_tag[i] = 3'h0; m_data[i] = 32'h0;
    end

    RESET = 1'b0;
    bus.READ = 1'b1;
    bus.WRITE = 1'b0;
    bus.ADDRESS = 8'h00;
    bus.WRITEDATA = 8'h00;
    bus.MEM_BUSYWAIT = 1'b1;
    bus.MEM_READDATA = 32'h0;

    // Reset held: outputs forced quiet even with a request pending
    #2;
    chk("rst_busywait", {31'b0, bus.BUSYWAIT}, 32'h0);
    chk("rst_readdata", {24'b0, bus.READDATA}, 32'h0);
    chk("rst_mem_rw",   {30'b0, bus.MEM_READ, bus.MEM_WRITE}, 32'h0);
    @(posedge CLK);
    #1;
    chk("rst_mem_addr", {26'b0, bus.MEM_ADDRESS}, 32'h0);
    chk("rst_mem_wd",   bus.MEM_WRITEDATA, 32'h0);
    RESET = 1'b1;
    idle_cycle();

    // Cold read miss, 3 busy memory cycles then completion
    run_access(1'b1, 1'b0, 8'h00, 8'h00, 1, 4);
    chk("s1_fetch_addr", {26'b0, obs_fa}, 32'h00);
    chk("s1_readdata",   {24'b0, obs_rd}, 32'h11);
    chk("s1_stall",      obs_busy_cycles, 5);
    run_access(1'b1, 1'b0, 8'h03, 8'h00, 1, 1);
    chk("s1_hit_rd3",    {24'b0, obs_rd}, 32'h44);
    chk("s1_hit_stall",  obs_busy_cycles, 0);

    // Write hit, then read back
    run_access(1'b0, 1'b1, 8'h01, 8'hAA, 1, 1);
    chk("s2_wr_stall", obs_busy_cycles, 0);
    run_access(1'b1, 1'b0, 8'h01, 8'h00, 1, 1);
    chk("s2_rd_aa", {24'b0, obs_rd}, 32'hAA);
    idle_cycle();

    // Conflict miss on dirty line
    run_access(1'b1, 1'b0, 8'h21, 8'h00, 2, 3);
    chk("s3_wb_seen", {31'b0, obs_wb_seen}, 32'h1);
    chk("s3_wb_addr", {26'b0, obs_wb_addr}, 32'h00);
    chk("s3_wb_data", obs_wb_data, 32'h4433AA11);
    chk("s3_fetch_addr", {26'b0, obs_fa}, 32'h08);
    chk("s3_readdata", {24'b0, obs_rd}, 32'hC8);
    chk("s3_stall", obs_busy_cycles, 6);

    // Write miss on invalid line, single-cycle memory
    run_access(1'b0, 1'b1, 8'h45, 8'h5A, 1, 1);
    chk("s4_wb_seen", {31'b0, obs_wb_seen}, 32'h0);
    chk("s4_fetch_addr", {26'b0, obs_fa}, 32'h11);
    chk("s4_stall", obs_busy_cycles, 2);
    run_access(1'b1, 1'b0, 8'h45, 8'h00, 1, 1);
    chk("s4_rd_5a", {24'b0, obs_rd}, 32'h5A);
    run_access(1'b1, 1'b0, 8'h25, 8'h00, 1, 1);
    chk("s4_evict_addr", {26'b0, obs_wb_addr}, 32'h11);
    chk("s4_evict_data", obs_wb_data, 32'hB1A15AC1);

    // Reset asserted mid-fetch
    bus.READ = 1'b1;
    bus.WRITE = 1'b0;
    bus.ADDRESS = 8'h03;
    cycle(mk(1'b1, 1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 8'h00), 1'b1, 32'h0);
    bus.MEM_BUSYWAIT = 1'b1;
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 6'h00, 32'h0, 1'b0, 8'h00));
    @(negedge CLK);
    #1;
    RESET = 1'b0;
    #1;
    chk("s5_mem_read", {31'b0, bus.MEM_READ}, 32'h0);
    chk("s5_busywait", {31'b0, bus.BUSYWAIT}, 32'h0);
    chk("s5_readdata", {24'b0, bus.READDATA}, 32'h0);
    chk("s5_mem_addr", {26'b0, bus.MEM_ADDRESS}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      m_v[i] = 1'b0; m_d[i] = 1'b0;
    end
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    bus.READ = 1'b0;
    idle_cycle();
    run_access(1'b1, 1'b0, 8'h03, 8'h00, 1, 2);
    chk("s5_refetch_addr", {26'b0, obs_fa}, 32'h00);
    chk("s5_refetch_rd", {24'b0, obs_rd}, 32'h44);
    chk("s5_refetch_nowb", {31'b0, obs_wb_seen}, 32'h0);

    // READ and WRITE together: served as read, line stays clean
    run_access(1'b1, 1'b1, 8'h03, 8'hFF, 1, 1);
    chk("s6_rd", {24'b0, obs_rd}, 32'h44);
    run_access(1'b1, 1'b0, 8'h03, 8'h00, 1, 1);
    chk("s6_still_44", {24'b0, obs_rd}, 32'h44);
    run_access(1'b1, 1'b0, 8'h23, 8'h00, 2, 2);
    chk("s6_clean_nowb", {31'b0, obs_wb_seen}, 32'h0);
    chk("s6_evict_rd", {24'b0, obs_rd}, 32'hA8);
    idle_cycle();

    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
